// File: rtl/dsp48_a1.sv
// dsp48_a1: pre-adder / 18x18 multiplier / 48-bit post-adder slice with optional pipeline stages
module dsp48_a1 #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [47:0] C,
    input  logic [17:0] D,
    input  logic [17:0] BCIN,
    input  logic        CARRYIN,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic        CARRYOUT,
    output logic        CARRYOUTF,
    input  logic        CLK,
    input  logic [7:0]  OPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CECARRYIN,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEOPMODE,
    input  logic        CEP,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTCARRYIN,
    input  logic        RSTD,
    input  logic        RSTM,
    input  logic        RSTOPMODE,
    input  logic        RSTP,
    output logic [17:0] BCOUT,
    input  logic [47:0] PCIN,
    output logic [47:0] PCOUT
);
    logic [17:0] a0_q, a1_q, b0_q, b1_q, d_q;
    logic [17:0] a0, a1, b0, b1, d, b_src, pre_d, b1_d;
    logic [47:0] c_q, c, p_q, x, z;
    logic [35:0] m_q, m_d;
    logic [7:0]  op_q, op;
    logic        cin_q, cin_d, cin, co_q;
    logic [48:0] post_d;

    assign b_src  = (B_INPUT == "DIRECT") ? B : (B_INPUT == "CASCADE") ? BCIN : 18'd0;
    assign a0     = (A0REG != 0) ? a0_q : A;
    assign a1     = (A1REG != 0) ? a1_q : a0;
    assign b0     = (B0REG != 0) ? b0_q : b_src;
    assign d      = (DREG != 0) ? d_q : D;
    assign c      = (CREG != 0) ? c_q : C;
    assign op     = (OPMODEREG != 0) ? op_q : OPMODE;
    assign pre_d  = op[6] ? d - b0 : d + b0;
    assign b1_d   = op[4] ? pre_d : b0;
    assign b1     = (B1REG != 0) ? b1_q : b1_d;
    assign m_d    = {18'd0, a1} * {18'd0, b1};
    assign M      = (MREG != 0) ? m_q : m_d;
    // P feedback taps the P register so an unregistered P never forms a combinational loop
    assign x      = (op[1:0] == 2'b00) ? 48'd0 : (op[1:0] == 2'b01) ? {12'd0, M} :
                    (op[1:0] == 2'b10) ? p_q : {d[11:0], a1, b1};
    assign z      = (op[3:2] == 2'b00) ? 48'd0 : (op[3:2] == 2'b01) ? PCIN :
                    (op[3:2] == 2'b10) ? p_q : c;
    assign cin_d  = (CARRYINSEL == "OPMODE5") ? op[5] : (CARRYINSEL == "CARRYIN") ? CARRYIN : 1'b0;
    assign cin    = (CARRYINREG != 0) ? cin_q : cin_d;
    assign post_d = op[7] ? {1'b0, z} - ({1'b0, x} + {48'd0, cin}) : {1'b0, z} + {1'b0, x} + {48'd0, cin};
    assign P         = (PREG != 0) ? p_q : post_d[47:0];
    assign CARRYOUT  = (CARRYOUTREG != 0) ? co_q : post_d[48];
    assign PCOUT     = P;
    assign CARRYOUTF = CARRYOUT;
    assign BCOUT     = b1;

    // A0 and A1 operand stages
    always_ff @(posedge CLK or posedge RSTA)
        if (RSTA) begin
            a0_q <= '0;
            a1_q <= '0;
        end else if (CEA) begin
            a0_q <= A;
            a1_q <= a0;
        end

    // B0 and B1 operand stages; B1 captures the pre-adder or bypassed B0
    always_ff @(posedge CLK or posedge RSTB)
        if (RSTB) begin
            b0_q <= '0;
            b1_q <= '0;
        end else if (CEB) begin
            b0_q <= b_src;
            b1_q <= b1_d;
        end

    // C post-adder operand stage
    always_ff @(posedge CLK or posedge RSTC)
        if (RSTC) c_q <= '0;
        else if (CEC) c_q <= C;

    // D pre-adder operand stage
    always_ff @(posedge CLK or posedge RSTD)
        if (RSTD) d_q <= '0;
        else if (CED) d_q <= D;

    // multiplier product stage
    always_ff @(posedge CLK or posedge RSTM)
        if (RSTM) m_q <= '0;
        else if (CEM) m_q <= m_d;

    // operation select stage
    always_ff @(posedge CLK or posedge RSTOPMODE)
        if (RSTOPMODE) op_q <= '0;
        else if (CEOPMODE) op_q <= OPMODE;

    // carry-in and carry-out stages share one enable and one reset
    always_ff @(posedge CLK or posedge RSTCARRYIN)
        if (RSTCARRYIN) begin
            cin_q <= 1'b0;
            co_q  <= 1'b0;
        end else if (CECARRYIN) begin
            cin_q <= cin_d;
            co_q  <= post_d[48];
        end

    // post-adder result stage
    always_ff @(posedge CLK or posedge RSTP)
        if (RSTP) p_q <= '0;
        else if (CEP) p_q <= post_d[47:0];
endmodule

// File: tb/tb_dsp48_a1.sv
// tb_dsp48_a1: directed vectors with a queued scoreboard for dsp48_a1
module tb_dsp48_a1;
    logic        CLK = 1'b0;
    logic [17:0] A, B, D, BCIN, BCOUT;
    logic [47:0] C, PCIN, P, PCOUT;
    logic [35:0] M;
    logic [7:0]  OPMODE;
    logic        CARRYIN, CARRYOUT, CARRYOUTF;
    logic        CEA, CEB, CEC, CECARRYIN, CED, CEM, CEOPMODE, CEP;
    logic        RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTOPMODE, RSTP;

    typedef struct {
        string       name;
        logic [17:0] bc;
        logic [35:0] m;
        logic [47:0] p;
        logic        co;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    logic tb_vld = 1'b0;

    always #5 CLK = ~CLK;

    dsp48_a1 dut (
        .A(A), .B(B), .C(C), .D(D), .BCIN(BCIN), .CARRYIN(CARRYIN),
        .M(M), .P(P), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF),
        .CLK(CLK), .OPMODE(OPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CECARRYIN(CECARRYIN),
        .CED(CED), .CEM(CEM), .CEOPMODE(CEOPMODE), .CEP(CEP),
        .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTCARRYIN(RSTCARRYIN),
        .RSTD(RSTD), .RSTM(RSTM), .RSTOPMODE(RSTOPMODE), .RSTP(RSTP),
        .BCOUT(BCOUT), .PCIN(PCIN), .PCOUT(PCOUT)
    );

    task automatic cmp(input string n, input string f, input logic [47:0] act, input logic [47:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", n, f, act, req);
        end
    endtask

    // monitor: every output strobe retires all queued expectations against the live outputs
    always @(posedge tb_vld) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp(e.name, "BCOUT", {30'd0, BCOUT}, {30'd0, e.bc});
            cmp(e.name, "M", {12'd0, M}, {12'd0, e.m});
            cmp(e.name, "P", P, e.p);
            cmp(e.name, "PCOUT", PCOUT, e.p);
            cmp(e.name, "CARRYOUT", {47'd0, CARRYOUT}, {47'd0, e.co});
            cmp(e.name, "CARRYOUTF", {47'd0, CARRYOUTF}, {47'd0, e.co});
        end
    end

    task automatic expect_out(input string n, input logic [17:0] bc, input logic [35:0] m,
                              input logic [47:0] p, input logic co);
        exp_t e;
        e.name = n;
        e.bc = bc;
        e.m = m;
        e.p = p;
        e.co = co;
        exp_q.push_back(e);
        tb_vld = 1'b1;
        #1 tb_vld = 1'b0;
    endtask

    task automatic set_rst(input logic v);
        {RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTOPMODE, RSTP} = {8{v}};
    endtask

    initial begin
        set_rst(1'b1);
        A = 18'($urandom);
        B = 18'($urandom);
        D = 18'($urandom);
        BCIN = 18'($urandom);
        C = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        PCIN = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        OPMODE = 8'($urandom);
        CARRYIN = 1'($urandom);
        {CEA, CEB, CEC, CECARRYIN, CED, CEM, CEOPMODE, CEP} = 8'($urandom);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        expect_out("all_reset", 18'd0, 36'd0, 48'd0, 1'b0);

        @(negedge CLK);
        set_rst(1'b0);
        {CEA, CEB, CEC, CECARRYIN, CED, CEM, CEOPMODE, CEP} = 8'hFF;
        A = 18'd20;
        B = 18'd10;
        C = 48'd350;
        D = 18'd25;
        BCIN = 18'd0;
        PCIN = 48'd0;
        CARRYIN = 1'b0;
        OPMODE = 8'hDD;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        expect_out("presub_mul_csub", 18'hF, 36'h12C, 48'h32, 1'b0);

        OPMODE = 8'h10;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        expect_out("preadd_zero", 18'h23, 36'h2BC, 48'd0, 1'b0);

        OPMODE = 8'h0A;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        expect_out("bypass_pfb", 18'hA, 36'hC8, 48'd0, 1'b0);

        A = 18'd5;
        B = 18'd6;
        D = 18'd25;
        PCIN = 48'd3000;
        OPMODE = 8'hA7;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        expect_out("concat_borrow", 18'd6, 36'h1E, 48'hFE6F_FFEC_0BB1, 1'b1);

        CEP = 1'b0;
        CECARRYIN = 1'b0;
        OPMODE = 8'h0C;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        expect_out("cep_hold", 18'd6, 36'h1E, 48'hFE6F_FFEC_0BB1, 1'b1);

        RSTP = 1'b1;
        #1;
        expect_out("rstp_async", 18'd6, 36'h1E, 48'd0, 1'b1);
        RSTCARRYIN = 1'b1;
        #1;
        expect_out("rstcarry_async", 18'd6, 36'h1E, 48'd0, 1'b0);
        RSTM = 1'b1;
        #1;
        expect_out("rstm_async", 18'd6, 36'd0, 48'd0, 1'b0);
        @(negedge CLK);
        set_rst(1'b0);
        CEP = 1'b1;
        CECARRYIN = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        expect_out("resume_c_pass", 18'd6, 36'h1E, 48'd350, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
